// File: rtl/past_sequence_recoverer_pkg.sv
// Shared constants and sizing helpers for the past-sequence recoverer.
package past_sequence_recoverer_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_DW = 8;

  // Window length in samples for a log2 window size n.
  function automatic int win_len(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/past_sequence_recoverer_recover_history.sv
// W x DW circular history of recovered samples, read-before-write at wr_ptr.
// Read is combinational; a write lands on the next edge. No backpressure.
module recover_history
  import past_sequence_recoverer_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int W = win_len(N);

  logic [DW-1:0] mem [W];
  logic [N-1:0]  wr_ptr;

  assign rdata = mem[wr_ptr];

  // A clear wipes the history; a write in the same cycle then lands in slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < W; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < W; i++) mem[i] <= '0;
      if (we) begin
        mem[0] <= wdata;
        wr_ptr <= N'(1);
      end else begin
        wr_ptr <= '0;
      end
    end else if (we) begin
      mem[wr_ptr] <= wdata;
      wr_ptr      <= wr_ptr + N'(1);
    end
  end

endmodule

// File: rtl/past_sequence_recoverer.sv
// Recovers samples x[n] from windowed sums: x[n] = s[n] - s[n-1] + x[n-W] (mod 2^DW).
// 1-cycle latency from accepting edge to out_valid; one sample per cycle, no backpressure.
module past_sequence_recoverer
  import past_sequence_recoverer_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] inp,
  output logic          out_valid,
  output logic [DW-1:0] outp,
  output logic          window_full
);

  localparam logic [N:0] W_C = (N+1)'(win_len(N));

  logic [DW-1:0] s_prev;
  logic [DW-1:0] hist_rdata;
  logic [DW-1:0] old_eff;
  logic [DW-1:0] s_prev_eff;
  logic [DW-1:0] x;
  logic [N:0]    fill_cnt;
  logic [N:0]    fill_base;
  logic [N:0]    fill_nxt;

  recover_history #(.N(N), .DW(DW)) u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .we    (in_valid),
    .wdata (x),
    .rdata (hist_rdata)
  );

  // A clear in the same cycle as a sample makes that sample see an all-zero past.
  always_comb begin
    old_eff    = clear ? '0 : hist_rdata;
    s_prev_eff = clear ? '0 : s_prev;
    x          = inp - s_prev_eff + old_eff;
    fill_base  = clear ? '0 : fill_cnt;
    fill_nxt   = fill_base;
    if (in_valid && (fill_base != W_C)) fill_nxt = fill_base + (N+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev      <= '0;
      fill_cnt    <= '0;
      outp        <= '0;
      out_valid   <= 1'b0;
      window_full <= 1'b0;
    end else begin
      fill_cnt    <= fill_nxt;
      window_full <= (fill_nxt == W_C);
      out_valid   <= in_valid;
      if (in_valid) begin
        s_prev <= inp;
        outp   <= x;
      end else if (clear) begin
        s_prev <= '0;
      end
    end
  end

endmodule

// File: tb/tb_past_sequence_recoverer.sv
// Directed bench for the past-sequence recoverer with N=2 (W=4), DW=8.
module tb_past_sequence_recoverer;

  localparam int N  = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic [DW-1:0] inp;
  logic          out_valid;
  logic [DW-1:0] outp;
  logic          window_full;

  int n_checks = 0;
  int n_fails  = 0;

  past_sequence_recoverer #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .inp         (inp),
    .out_valid   (out_valid),
    .outp        (outp),
    .window_full (window_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic step(input logic v, input logic c, input logic [DW-1:0] d);
    @(negedge clk);
    in_valid = v;
    clear    = c;
    inp      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic vld, input logic [DW-1:0] val,
                            input logic wf);
    check({tag, ".vld"}, 32'(out_valid), 32'(vld));
    if (vld) check({tag, ".outp"}, 32'(outp), 32'(val));
    check({tag, ".wf"}, 32'(window_full), 32'(wf));
  endtask

  initial begin
    logic [DW-1:0] sums_a [6];
    logic [DW-1:0] ref_x  [4];
    logic [DW-1:0] ref_s;

    sums_a = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd14, 8'd18};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; inp = '0;
    #12;
    check("rst.outp", 32'(outp), 32'd0);
    check("rst.vld", 32'(out_valid), 32'd0);
    check("rst.wf", 32'(window_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream across one wrap of the history.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, sums_a[i]);
      expect_out($sformatf("seq%0d", i), 1'b1, DW'(i + 1), i >= 3);
    end
    step(1'b0, 1'b0, 8'd0);
    expect_out("idle", 1'b0, 8'd0, 1'b1);
    check("idle.hold", 32'(outp), 32'd6);

    // Modular difference: 44 - 200 wraps to 100.
    step(1'b1, 1'b1, 8'd200);
    expect_out("wrap0", 1'b1, 8'd200, 1'b0);
    step(1'b1, 1'b0, 8'd44);
    expect_out("wrap1", 1'b1, 8'd100, 1'b0);

    // Gaps in in_valid.
    step(1'b0, 1'b1, 8'd0);
    expect_out("clr_only", 1'b0, 8'd0, 1'b0);
    check("clr_only.hold", 32'(outp), 32'd100);
    step(1'b1, 1'b0, 8'd1);
    expect_out("gap0", 1'b1, 8'd1, 1'b0);
    step(1'b1, 1'b0, 8'd3);
    expect_out("gap1", 1'b1, 8'd2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 8'd99);
      expect_out($sformatf("gap_idle%0d", i), 1'b0, 8'd0, 1'b0);
      check($sformatf("gap_hold%0d", i), 32'(outp), 32'd2);
    end
    step(1'b1, 1'b0, 8'd6);
    expect_out("gap2", 1'b1, 8'd3, 1'b0);
    step(1'b1, 1'b0, 8'd10);
    expect_out("gap3", 1'b1, 8'd4, 1'b1);

    // Clear together with a sample, mid-stream.
    step(1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b0, 8'd1);
    step(1'b1, 1'b0, 8'd3);
    step(1'b1, 1'b0, 8'd6);
    expect_out("mid2", 1'b1, 8'd3, 1'b0);
    step(1'b1, 1'b1, 8'd7);
    expect_out("clrv", 1'b1, 8'd7, 1'b0);
    step(1'b1, 1'b0, 8'd15);
    expect_out("clrv_next", 1'b1, 8'd8, 1'b0);

    // Asynchronous reset between edges.
    step(1'b1, 1'b0, 8'd20);
    expect_out("pre_rst", 1'b1, 8'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst.vld", 32'(out_valid), 32'd0);
    check("arst.outp", 32'(outp), 32'd0);
    check("arst.wf", 32'(window_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'd5);
    expect_out("post_rst", 1'b1, 8'd5, 1'b0);

    // Long run: x = 1..12 through a reference windowed summer, three pointer wraps.
    step(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 4; i++) ref_x[i] = '0;
    for (int i = 1; i <= 12; i++) begin
      ref_x[i % 4] = DW'(i);
      ref_s = ref_x[0] + ref_x[1] + ref_x[2] + ref_x[3];
      step(1'b1, 1'b0, ref_s);
      expect_out($sformatf("long%0d", i), 1'b1, DW'(i), i >= 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
